// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the chunked adder.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nchunk(input int w, input int c);
    return w / c;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunked_adder_slice.sv
// CHUNK-bit combinational ripple slice.
// With ADDER_OVF_EN the carry into the slice MSB is exported.
module chunk_slice #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
`ifdef ADDER_OVF_EN
  output logic             cm,
`endif
  output logic             co
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co = c[CHUNK];
`ifdef ADDER_OVF_EN
  assign cm = c[CHUNK-1];
`endif

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle add/sub, one CHUNK-bit slice per cycle, valid/ready on both sides.
// Define ADDER_OVF_EN to add the signed-overflow output ovf.
module chunked_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IW     = idx_width(NCHUNK);
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  state_t           state;
  logic             live;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;

  logic [CHUNK-1:0] s;
  logic             co;
`ifdef ADDER_OVF_EN
  logic             cm;
`endif

  chunk_slice #(.CHUNK(CHUNK)) u_slice (
    .a  (opa[int'(idx)*CHUNK +: CHUNK]),
    .b  (opb[int'(idx)*CHUNK +: CHUNK]),
    .ci (carry),
    .s  (s),
`ifdef ADDER_OVF_EN
    .cm (cm),
`endif
    .co (co)
  );

  // live keeps in_ready low for the cycle after reset release
  assign in_ready  = (state == IDLE) && live;
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      live  <= 1'b0;
      idx   <= '0;
      carry <= 1'b0;
      opa   <= '0;
      opb   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      live <= 1'b1;
      unique case (state)
        IDLE: begin
          if (in_valid && live) begin
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub | cin;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum[int'(idx)*CHUNK +: CHUNK] <= s;
          carry <= co;
          idx   <= idx + IW'(1);
          if (idx == LAST) begin
            cout  <= co;
`ifdef ADDER_OVF_EN
            ovf   <= cm ^ co;
`endif
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_adder.sv
// Directed, table-driven bench for chunked_adder (8/2 and 9/3 builds).
module tb_chunked_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, b, sum;
  logic       cin, sub, cout;
  logic       in_valid9, in_ready9, out_valid9, out_ready9;
  logic [8:0] a9, b9, sum9;
  logic       cin9, sub9, cout9;
`ifdef ADDER_OVF_EN
  logic       ovf, ovf9;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  chunked_adder #(.WIDTH(8), .CHUNK(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum),
`ifdef ADDER_OVF_EN
    .ovf(ovf),
`endif
    .cout(cout)
  );

  chunked_adder #(.WIDTH(9), .CHUNK(3)) dut9 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid9), .in_ready(in_ready9),
    .a(a9), .b(b9), .cin(cin9), .sub(sub9),
    .out_valid(out_valid9), .out_ready(out_ready9),
    .sum(sum9),
`ifdef ADDER_OVF_EN
    .ovf(ovf9),
`endif
    .cout(cout9)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       c;
    logic       o;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_,
                        input logic tc, input logic ts,
                        output logic [7:0] rs, output logic rc,
                        output logic ro, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    rs = sum;
    rc = cout;
`ifdef ADDER_OVF_EN
    ro = ovf;
`else
    ro = 1'b0;
`endif
    @(posedge clk); #1;
  endtask

  task automatic run9(input logic [8:0] ta, input logic [8:0] tb_,
                      input logic ts, output logic [8:0] rs,
                      output logic rc, output logic ro, output int lat);
    int n;
    n = 0;
    while (!in_ready9 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    a9 = ta; b9 = tb_; cin9 = 1'b0; sub9 = ts; in_valid9 = 1'b1;
    @(posedge clk); #1;
    in_valid9 = 1'b0;
    lat = 0;
    while (!out_valid9 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    rs = sum9;
    rc = cout9;
`ifdef ADDER_OVF_EN
    ro = ovf9;
`else
    ro = 1'b0;
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] rs;
    logic [8:0] rs9;
    logic       rc, ro;
    int         lat, n;
    bit         seen;

    //          a    b    cin  sub  sum  cout ovf
    vt[0]  = '{8'd6,   8'd1,   1'b0, 1'b0, 8'd7,   1'b0, 1'b0};
    vt[1]  = '{8'd200, 8'd100, 1'b0, 1'b0, 8'd44,  1'b1, 1'b0};
    vt[2]  = '{8'd100, 8'd100, 1'b0, 1'b0, 8'd200, 1'b0, 1'b1};
    vt[3]  = '{8'd5,   8'd4,   1'b1, 1'b0, 8'd10,  1'b0, 1'b0};
    vt[4]  = '{8'd5,   8'd4,   1'b1, 1'b1, 8'd1,   1'b1, 1'b0};
    vt[5]  = '{8'd2,   8'd3,   1'b0, 1'b1, 8'd255, 1'b0, 1'b0};
    vt[6]  = '{8'd255, 8'd1,   1'b0, 1'b0, 8'd0,   1'b1, 1'b0};
    vt[7]  = '{8'd128, 8'd1,   1'b0, 1'b1, 8'd127, 1'b1, 1'b1};
    vt[8]  = '{8'd0,   8'd0,   1'b1, 1'b0, 8'd1,   1'b0, 1'b0};
    vt[9]  = '{8'd0,   8'd0,   1'b0, 1'b1, 8'd0,   1'b1, 1'b0};
    vt[10] = '{8'd127, 8'd1,   1'b0, 1'b0, 8'd128, 1'b0, 1'b1};
    vt[11] = '{8'd100, 8'd200, 1'b0, 1'b1, 8'd156, 1'b0, 1'b1};

    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b1;
    in_valid9 = 1'b0; a9 = '0; b9 = '0; cin9 = 1'b0; sub9 = 1'b0;
    out_ready9 = 1'b1;

    // reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_cout", 32'(cout), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", 32'(in_ready), 1);

    // table vectors
    for (int i = 0; i < 12; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, rs, rc, ro, lat);
      chk($sformatf("v%0d_sum", i), 32'(rs), 32'(vt[i].s));
      chk($sformatf("v%0d_cout", i), 32'(rc), 32'(vt[i].c));
      chk($sformatf("v%0d_lat", i), 32'(lat), 4);
`ifdef ADDER_OVF_EN
      chk($sformatf("v%0d_ovf", i), 32'(ro), 32'(vt[i].o));
`endif
    end

    // backpressure
    out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    a = 8'd3; b = 8'd4; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("bp_lat", 32'(n), 4);
    a = 8'd9; b = 8'd0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_valid%0d", k), 32'(out_valid), 1);
      chk($sformatf("bp_sum%0d", k), 32'(sum), 7);
      chk($sformatf("bp_ready%0d", k), 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_drop_valid", 32'(out_valid), 0);
    chk("bp_idle_ready", 32'(in_ready), 1);
    run_op(8'd9, 8'd0, 1'b0, 1'b0, rs, rc, ro, lat);
    chk("bp_next_sum", 32'(rs), 9);
    chk("bp_next_lat", 32'(lat), 4);

    // reset in the second RUN cycle
    a = 8'd6; b = 8'd1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_rst_sum", 32'(sum), 0);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("mid_rst_no_valid", 32'(seen), 0);
    chk("mid_rst_ready", 32'(in_ready), 1);

    // 9-bit, 3-bit chunks
    run9(9'd511, 9'd1, 1'b0, rs9, rc, ro, lat);
    chk("w9_sum", 32'(rs9), 0);
    chk("w9_cout", 32'(rc), 1);
    chk("w9_lat", 32'(lat), 3);
`ifdef ADDER_OVF_EN
    chk("w9_ovf", 32'(ro), 0);
`endif
    run9(9'd0, 9'd1, 1'b1, rs9, rc, ro, lat);
    chk("w9_sub_sum", 32'(rs9), 511);
    chk("w9_sub_cout", 32'(rc), 0);
    chk("w9_sub_lat", 32'(lat), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chunked_adder.md
# chunked_adder

Parametrised multi-cycle adder/subtractor that succeeds the fixed three-bit ripple adder. It adds or subtracts two WIDTH-bit operands over WIDTH/CHUNK clock cycles, using one CHUNK-bit ripple slice and a registered carry between slices. It sits behind valid/ready handshakes on both sides, so an upstream producer and a downstream consumer can stall it.

## Interface
- WIDTH, 8, operand and result width; must be a multiple of CHUNK.
- CHUNK, 2, bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept an operand.
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in, add mode only.
- sub  in  1  1 computes a − b; cin is ignored.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry-out; in sub mode, 1 means no borrow.
- ovf  out  1  signed overflow. Present only with ADDER_OVF_EN.

## Operation
- NCHUNK = WIDTH/CHUNK. The chunk index counter is clog2(NCHUNK) bits wide, minimum 1.
- **States:** IDLE, RUN, DONE.
- **IDLE**
  - in_ready = 1.
  - On in_valid, capture a into opa.
  - Capture b into opb, inverted when sub = 1.
  - Set carry = sub ? 1 : cin.
  - Clear sum, cout and ovf; set idx = 0; go to RUN.
- **RUN**
  - in_ready = 0.
  - Each cycle:
    - feed chunk idx of opa, opb and carry to the slice;
    - write the slice sum into sum[idx*CHUNK +: CHUNK];
    - store the slice carry-out in carry;
    - increment idx.
  - When idx = NCHUNK−1, the final carry-out goes to cout and the state moves to DONE.
- **DONE**
  - out_valid = 1.
  - sum, cout and ovf are held stable.
  - When out_ready = 1 at the clock edge, go to IDLE.
- **Input side:** in_valid is ignored outside IDLE. Operand inputs are sampled only at the accepting edge.
- **Arithmetic:** result is (a + b + cin) mod 2^WIDTH, or (a + ~b + 1) mod 2^WIDTH in sub mode. cout is bit WIDTH of that sum.
- **WIDTH = CHUNK:** NCHUNK = 1, so RUN lasts exactly one cycle.
- **Reset**
  - While rst_n = 0 at an edge, the next state is IDLE.
  - out_valid, sum, cout and ovf are 0; idx and carry are 0.
  - in_ready is driven 0 while rst_n is low.
  - Reset during RUN or DONE aborts the operation; no out_valid pulse follows.

## Timing
- The operation is accepted at edge E0, where in_valid and in_ready are both 1.
- out_valid rises after edge E_NCHUNK, i.e. NCHUNK cycles after acceptance.
- Minimum spacing between accepts is NCHUNK + 2 cycles: the RUN cycles, one DONE handshake edge, then one IDLE cycle.
- No combinational path from inputs to outputs. in_ready and out_valid are decoded from the state register only.
- out_ready low holds DONE indefinitely with the result unchanged.

## Configuration
- **ADDER_OVF_EN defined**
  - The ovf port exists.
  - On the last chunk, ovf = (carry into bit WIDTH−1) XOR (carry out of bit WIDTH−1).
  - ovf is registered with cout and held in DONE.
- **ADDER_OVF_EN undefined**
  - There is no ovf port and no MSB carry tracking.
  - All other behaviour is identical.

## Structure
- **Package adder_pkg:**
  - state enum {IDLE, RUN, DONE};
  - a function computing NCHUNK and the index width.
- **Sub-module chunk_slice**
  - Combinational CHUNK-bit ripple of full adders, parameter CHUNK.
  - Outputs sum, carry-out, and carry into its MSB (the last is used for ovf).
- **Top level:** the FSM, operand registers, index counter and result register.

## Test plan
All scenarios use WIDTH = 8, CHUNK = 2 (NCHUNK = 4) unless stated.
- **Reset:** rst_n low for 2 cycles → in_ready = 0, out_valid = 0, sum = 0, cout = 0. After release, in_ready = 1 on the next cycle.
- **Add:** a = 6, b = 1, cin = 0, sub = 0 → out_valid exactly 4 cycles after accept; sum = 7, cout = 0. Then a = 200, b = 100 → sum = 44, cout = 1.
- **Overflow:** a = 100, b = 100 → sum = 200, cout = 0, and with ADDER_OVF_EN, ovf = 1. a = 5, b = 4, cin = 1 → sum = 10, ovf = 0.
- **Subtract:**
  - a = 5, b = 4, sub = 1, cin = 1 → sum = 1, cout = 1.
  - a = 2, b = 3, sub = 1 → sum = 255, cout = 0, ovf = 0.
- **Backpressure:** out_ready held low for 5 cycles in DONE → out_valid and sum stay stable, in_ready = 0. in_valid with a = 9 in that window is not accepted. After out_ready = 1, the next accept takes the new operands.
- **Mid-operation reset and alternate width:**
  - rst_n low in the 2nd RUN cycle → out_valid never asserts; in_ready = 1 after release.
  - Rerun with WIDTH = 9, CHUNK = 3: a = 511, b = 1 → sum = 0, cout = 1, latency 3 cycles.
